seq_scan_ctrl: RTL

//  Shares one serial sequence detector (fsm_seq_dec: clk/rst/inp/outp) between N requesters.

---
 rtl/seq_scan_pkg.sv | 22 ++
 rtl/seq_scan_ctrl_rr_arb.sv | 43 ++++
 rtl/seq_scan_ctrl.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/seq_scan_pkg.sv
// rtl/seq_scan_pkg.sv - shared state encodings and width helper for the sequence scan controller
package seq_scan_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_SHIFT = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_CLR   = ST_CLR,
        S_SHIFT = ST_SHIFT,
        S_DRAIN = ST_DRAIN,
        S_DONE  = ST_DONE
    } state_t;

    function automatic int cw_f(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_scan_ctrl_rr_arb.sv
// rtl/seq_scan_ctrl_rr_arb.sv - N-way round-robin arbiter, combinational grant, registered pointer
module rr_arb #(
    parameter  int N  = 2,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req_i,
    input  logic          upd_i,
    input  logic [IW-1:0] upd_idx_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o
);

    logic [IW-1:0] ptr_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (upd_i) begin
            ptr_q <= (upd_idx_i == IW'(N - 1)) ? '0 : upd_idx_i + 1'b1;
        end
    end

    // Scan from the pointer upward with wraparound; first requester found wins.
    always_comb begin
        logic          found;
        logic [IW-1:0] idx;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(ptr_q) + k) % N);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                gnt_idx_o  = idx;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// rtl/seq_scan_ctrl.sv - shares one serial sequence detector between N requesters
// Optional SEQ_SCAN_FIRST_HIT_EN adds first_idx (stream position of the first hit).
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter  int N       = 2,
    parameter  int W       = 8,
    parameter  int DET_LAT = 1,
    localparam int CW      = cw_f(W),
    localparam int IW      = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*W-1:0]  data,
    output logic [N-1:0]    gnt,
    output logic            busy,
    output logic            done,
    output logic [IW-1:0]   done_id,
    output logic [CW-1:0]   hit_cnt,
`ifdef SEQ_SCAN_FIRST_HIT_EN
    output logic [CW-1:0]   first_idx,
`endif
    output logic            det_rst,
    output logic            det_inp,
    input  logic            det_outp
);

    state_t               state_q, state_d;
    logic [N-1:0]         gnt_q;
    logic [IW-1:0]        gidx_q, done_id_q;
    logic [W-1:0]         sreg_q;
    logic [CW-1:0]        bit_q, cnt_q, cnt_d, sidx_q, hit_cnt_q;
    logic [1:0]           drn_q;
    logic [DET_LAT-1:0]   vld_q;
    logic [N-1:0]         arb_gnt;
    logic [IW-1:0]        arb_idx;
    logic                 smp, hit, fin;

    rr_arb #(.N(N)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req_i     (req),
        .upd_i     (state_q == S_DONE),
        .upd_idx_i (gidx_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|req) state_d = S_CLR;
            S_CLR:   state_d = S_SHIFT;
            S_SHIFT: if (bit_q == CW'(W - 1)) state_d = S_DRAIN;
            S_DRAIN: if (drn_q == 2'(DET_LAT - 1)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The valid delay line aligns each streamed bit with the detector's answer for it.
    assign smp   = vld_q[DET_LAT-1];
    assign hit   = smp & det_outp;
    assign cnt_d = (hit && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    assign fin   = (state_q == S_DRAIN) && (state_d == S_DONE);

`ifdef SEQ_SCAN_FIRST_HIT_EN
    logic [CW-1:0] fst_q, fst_d, first_q;
    assign fst_d     = (hit && fst_q == '1) ? sidx_q : fst_q;
    assign first_idx = first_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            fst_q   <= '1;
            first_q <= '1;
        end else begin
            if (smp) fst_q <= fst_d;
            if (fin) first_q <= fst_d;
            if (state_q == S_IDLE && |req) fst_q <= '1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            gnt_q     <= '0;
            gidx_q    <= '0;
            sreg_q    <= '0;
            bit_q     <= '0;
            drn_q     <= '0;
            vld_q     <= '0;
            cnt_q     <= '0;
            sidx_q    <= '0;
            hit_cnt_q <= '0;
            done_id_q <= '0;
        end else begin
            state_q <= state_d;
            vld_q   <= (vld_q << 1) | DET_LAT'(state_q == S_SHIFT);
            if (smp) begin
                cnt_q  <= cnt_d;
                sidx_q <= sidx_q + 1'b1;
            end
            if (fin) begin
                hit_cnt_q <= cnt_d;
                done_id_q <= gidx_q;
            end
            case (state_q)
                S_IDLE: begin
                    if (|req) begin
                        gnt_q  <= arb_gnt;
                        gidx_q <= arb_idx;
                        sreg_q <= data[arb_idx*W +: W];
                        bit_q  <= '0;
                        cnt_q  <= '0;
                        sidx_q <= '0;
                    end
                end
                S_SHIFT: begin
                    sreg_q <= sreg_q << 1;
                    bit_q  <= bit_q + 1'b1;
                    drn_q  <= '0;
                end
                S_DRAIN: drn_q <= drn_q + 1'b1;
                S_DONE:  gnt_q <= '0;
                default: ;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign busy    = (state_q != S_IDLE);
    assign done    = (state_q == S_DONE);
    assign done_id = done_id_q;
    assign hit_cnt = hit_cnt_q;
    assign det_rst = (state_q == S_IDLE) || (state_q == S_CLR) || (state_q == S_DONE);
    assign det_inp = (state_q == S_SHIFT) & sreg_q[W-1];

endmodule
